// File: rtl/tlp_fc_credit_gate.sv
// Transmit flow-control gate: holds each TLP header until the partner's credit limits admit it.
// Optional FC_GATE_INFINITE_CREDIT_EN: fields first advertised as 0 become sticky infinite credit.
module tlp_fc_credit_gate #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,

    input  logic [7:0]            tx_fc_ph_i,
    input  logic [7:0]            tx_fc_nph_i,
    input  logic [7:0]            tx_fc_cplh_i,
    input  logic [11:0]           tx_fc_pd_i,
    input  logic [11:0]           tx_fc_npd_i,
    input  logic [11:0]           tx_fc_cpld_i,
    input  logic                  update_fc_i,

    output logic                  blocked_o,
    output logic [7:0]            cc_ph_o,
    output logic [7:0]            cc_nph_o,
    output logic [7:0]            cc_cplh_o,
    output logic [11:0]           cc_pd_o,
    output logic [11:0]           cc_npd_o,
    output logic [11:0]           cc_cpld_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_SEND_HDR = 2'd2;
    localparam logic [1:0] ST_STREAM   = 2'd3;

    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    // Modulo-window credit tests: the limit may sit at most half the counter range ahead.
    function automatic logic hdr_fits(input logic [7:0] cl, input logic [7:0] cc,
                                      input logic [7:0] req);
        logic [7:0] room;
        room = cl - (cc + req);
        return room <= 8'h80;
    endfunction

    function automatic logic data_fits(input logic [11:0] cl, input logic [11:0] cc,
                                       input logic [11:0] req);
        logic [11:0] room;
        room = cl - (cc + req);
        return room <= 12'h800;
    endfunction

    function automatic logic [11:0] data_credits(input logic [2:0] fmt, input logic [9:0] len);
        if (!fmt[1])
            return 12'd0;
        if (len == 10'd0)
            return 12'd256;
        return ({2'b00, len} + 12'd3) >> 2;
    endfunction

    function automatic logic [1:0] tlp_class(input logic [2:0] fmt, input logic [4:0] typ);
        if (typ == 5'b01010 || typ == 5'b01011)
            return CLS_CPL;
        if (typ[4:3] == 2'b10)
            return CLS_P;
        if (fmt[1] && typ == 5'b00000)
            return CLS_P;
        return CLS_NP;
    endfunction

    logic [1:0]            state;
    logic [7:0]            lim_ph, lim_nph, lim_cplh;
    logic [11:0]           lim_pd, lim_npd, lim_cpld;
    logic [7:0]            cc_ph, cc_nph, cc_cplh;
    logic [11:0]           cc_pd, cc_npd, cc_cpld;

    logic [DATA_WIDTH-1:0] hdr_data_p0;
    logic [KEEP_WIDTH-1:0] hdr_keep_p0;
    logic                  hdr_last_p0;
    logic [USER_WIDTH-1:0] hdr_user_p0;
    logic [1:0]            hdr_cls_p0;
    logic [11:0]           hdr_dreq_p0;

    // Infinite flags, bit order {cpld, npd, pd, cplh, nph, ph}.
    logic [5:0]            inf;

    logic [7:0]            sel_cl_h, sel_cc_h;
    logic [11:0]           sel_cl_d, sel_cc_d;
    logic                  sel_inf_h, sel_inf_d;
    logic                  credit_ok;
    logic                  ready_int;

`ifdef FC_GATE_INFINITE_CREDIT_EN
    logic first_update_seen;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inf               <= '0;
            first_update_seen <= 1'b0;
        end else if (update_fc_i && !first_update_seen) begin
            first_update_seen <= 1'b1;
            inf <= {tx_fc_cpld_i == 12'd0, tx_fc_npd_i == 12'd0, tx_fc_pd_i == 12'd0,
                    tx_fc_cplh_i == 8'd0, tx_fc_nph_i == 8'd0, tx_fc_ph_i == 8'd0};
        end
    end
`else
    assign inf = '0;
`endif

    always_comb begin
        sel_cl_h  = lim_ph;
        sel_cc_h  = cc_ph;
        sel_cl_d  = lim_pd;
        sel_cc_d  = cc_pd;
        sel_inf_h = inf[0];
        sel_inf_d = inf[3];
        case (hdr_cls_p0)
            CLS_NP: begin
                sel_cl_h  = lim_nph;
                sel_cc_h  = cc_nph;
                sel_cl_d  = lim_npd;
                sel_cc_d  = cc_npd;
                sel_inf_h = inf[1];
                sel_inf_d = inf[4];
            end
            CLS_CPL: begin
                sel_cl_h  = lim_cplh;
                sel_cc_h  = cc_cplh;
                sel_cl_d  = lim_cpld;
                sel_cc_d  = cc_cpld;
                sel_inf_h = inf[2];
                sel_inf_d = inf[5];
            end
            default: ;
        endcase
        credit_ok = (sel_inf_h || hdr_fits(sel_cl_h, sel_cc_h, 8'd1)) &&
                    (sel_inf_d || data_fits(sel_cl_d, sel_cc_d, hdr_dreq_p0));
    end

    // Stage p0: captured first beat and its decoded credit requirement.
    always_ff @(posedge clk_i) begin
        if (state == ST_IDLE && s_axis_tvalid) begin
            hdr_data_p0 <= s_axis_tdata;
            hdr_keep_p0 <= s_axis_tkeep;
            hdr_last_p0 <= s_axis_tlast;
            hdr_user_p0 <= s_axis_tuser;
            hdr_cls_p0  <= tlp_class(s_axis_tdata[31:29], s_axis_tdata[28:24]);
            hdr_dreq_p0 <= data_credits(s_axis_tdata[31:29], s_axis_tdata[9:0]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            lim_ph   <= '0;
            lim_nph  <= '0;
            lim_cplh <= '0;
            lim_pd   <= '0;
            lim_npd  <= '0;
            lim_cpld <= '0;
            cc_ph    <= '0;
            cc_nph   <= '0;
            cc_cplh  <= '0;
            cc_pd    <= '0;
            cc_npd   <= '0;
            cc_cpld  <= '0;
        end else begin
            if (update_fc_i) begin
                lim_ph   <= tx_fc_ph_i;
                lim_nph  <= tx_fc_nph_i;
                lim_cplh <= tx_fc_cplh_i;
                lim_pd   <= tx_fc_pd_i;
                lim_npd  <= tx_fc_npd_i;
                lim_cpld <= tx_fc_cpld_i;
            end
            case (state)
                ST_IDLE: begin
                    if (s_axis_tvalid)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (credit_ok) begin
                        state <= ST_SEND_HDR;
                        case (hdr_cls_p0)
                            CLS_P: begin
                                if (!inf[0]) cc_ph <= cc_ph + 8'd1;
                                if (!inf[3]) cc_pd <= cc_pd + hdr_dreq_p0;
                            end
                            CLS_NP: begin
                                if (!inf[1]) cc_nph <= cc_nph + 8'd1;
                                if (!inf[4]) cc_npd <= cc_npd + hdr_dreq_p0;
                            end
                            default: begin
                                if (!inf[2]) cc_cplh <= cc_cplh + 8'd1;
                                if (!inf[5]) cc_cpld <= cc_cpld + hdr_dreq_p0;
                            end
                        endcase
                    end
                end
                ST_SEND_HDR: begin
                    if (m_axis_tready)
                        state <= hdr_last_p0 ? ST_IDLE : ST_STREAM;
                end
                default: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        ready_int     = 1'b0;
        case (state)
            ST_IDLE: ready_int = 1'b1;
            ST_SEND_HDR: begin
                m_axis_tdata  = hdr_data_p0;
                m_axis_tkeep  = hdr_keep_p0;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = hdr_last_p0;
                m_axis_tuser  = hdr_user_p0;
            end
            ST_STREAM: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                ready_int     = m_axis_tready;
            end
            default: ;
        endcase
    end

    // Reset parks the FSM in IDLE, so the ready it would otherwise show is masked here.
    assign s_axis_tready = ready_int && !rst_i;
    assign blocked_o     = (state == ST_CHECK) && !credit_ok;

    assign cc_ph_o   = cc_ph;
    assign cc_nph_o  = cc_nph;
    assign cc_cplh_o = cc_cplh;
    assign cc_pd_o   = cc_pd;
    assign cc_npd_o  = cc_npd;
    assign cc_cpld_o = cc_cpld;

endmodule

// File: tb/tb_tlp_fc_credit_gate.sv
// Directed bench for tlp_fc_credit_gate: credit blocking, release, wrap and latency.
module tb_tlp_fc_credit_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic        m_tready;
    logic [7:0]  lim_ph, lim_nph, lim_cplh;
    logic [11:0] lim_pd, lim_npd, lim_cpld;
    logic        update_fc;

    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        blocked_o;
    logic [7:0]  cc_ph, cc_nph, cc_cplh;
    logic [11:0] cc_pd, cc_npd, cc_cpld;

    int n_asserts = 0;
    int n_fail    = 0;

    tlp_fc_credit_gate #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_tready),
        .tx_fc_ph_i(lim_ph), .tx_fc_nph_i(lim_nph), .tx_fc_cplh_i(lim_cplh),
        .tx_fc_pd_i(lim_pd), .tx_fc_npd_i(lim_npd), .tx_fc_cpld_i(lim_cpld),
        .update_fc_i(update_fc), .blocked_o(blocked_o),
        .cc_ph_o(cc_ph), .cc_nph_o(cc_nph), .cc_cplh_o(cc_cplh),
        .cc_pd_o(cc_pd), .cc_npd_o(cc_npd), .cc_cpld_o(cc_cpld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_blocked", 64'(blocked_o), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_cc_hdr", 64'({cc_ph, cc_nph, cc_cplh}), 64'd0);
        check("rst_cc_data", 64'({cc_pd, cc_npd, cc_cpld}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        update_fc = 1'b0;
        lim_ph = 8'd0; lim_nph = 8'd0; lim_cplh = 8'd0;
        lim_pd = 12'd0; lim_npd = 12'd0; lim_cpld = 12'd0;
        step(1);
        check_reset_state();
        rst = 1'b0;
        step(1);
    endtask

    task automatic do_update(output logic blk_mid);
        update_fc = 1'b1;
        @(negedge clk);
        blk_mid = blocked_o;
        @(posedge clk);
        #1;
        update_fc = 1'b0;
    endtask

    task automatic push_hdr(input logic [31:0] dw0, input logic last, output bit ok);
        s_tdata = dw0;
        s_tlast = last;
        s_tuser = 1'b1;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (s_axis_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
    endtask

    // Returns how many mid-cycle samples passed before the header showed up on m_axis.
    task automatic wait_hdr(output int lat, output logic [33:0] beat);
        lat = -1;
        beat = '0;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                lat = i;
                beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_body(input int n, input logic [31:0] base, output int errs);
        bit done;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            s_tdata = base + 32'(i);
            s_tlast = (i == n - 1);
            s_tuser = i[0];
            s_tvalid = 1'b1;
            done = 1'b0;
            for (int j = 0; j < 4 && !done; j++) begin
                @(negedge clk);
                if (s_axis_tready) begin
                    done = 1'b1;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== s_tdata ||
                        m_axis_tlast !== s_tlast || m_axis_tuser !== s_tuser ||
                        m_axis_tkeep !== s_tkeep)
                        errs++;
                end
                @(posedge clk);
                #1;
            end
            if (!done) errs++;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_tlp(input string tag, input logic [31:0] dw0, input int ndata,
                            input logic [31:0] base);
        bit ok;
        int lat;
        int errs;
        logic [33:0] beat;
        push_hdr(dw0, ndata == 0, ok);
        check({tag, "_accept"}, 64'(ok), 64'd1);
        wait_hdr(lat, beat);
        check({tag, "_latency"}, 64'(lat), 64'd1);
        check({tag, "_hdr"}, 64'(beat), 64'({ndata == 0, 1'b1, dw0}));
        if (ndata > 0) begin
            send_body(ndata, base, errs);
            check({tag, "_body"}, 64'(errs), 64'd0);
        end
    endtask

    task automatic check_blocked(input string tag);
        step(3);
        @(negedge clk);
        check({tag, "_blocked"}, 64'(blocked_o), 64'd1);
        check({tag, "_mvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_sready"}, 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        blk;
        bit          ok;
        int          lat;
        int          cum;
        logic [33:0] beat;

        rst = 1'b1;
        s_tdata = '0;
        s_tkeep = 4'hF;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        m_tready = 1'b1;
        update_fc = 1'b0;
        step(2);
        do_reset();

`ifndef FC_GATE_INFINITE_CREDIT_EN
        // MRd with no non-posted credit advertised stays blocked.
        lim_ph = 8'd8; lim_pd = 12'd64;
        do_update(blk);
        push_hdr(32'h0000_0001, 1'b1, ok);
        check("mrd_accept", 64'(ok), 64'd1);
        check_blocked("mrd_early");
        step(20);
        check_blocked("mrd_late");
        check("mrd_cc_nph", 64'(cc_nph), 64'd0);
        // A limit update only takes effect on the cycle after the strobe.
        lim_nph = 8'd1;
        do_update(blk);
        check("mrd_old_limit", 64'(blk), 64'd1);
        wait_hdr(lat, beat);
        check("mrd_latency", 64'(lat), 64'd1);
        check("mrd_hdr", 64'(beat), 64'({1'b1, 1'b1, 32'h0000_0001}));
        check("mrd_cc_np", 64'({cc_nph, cc_npd}), 64'({8'd1, 12'd0}));

        // MWr len 16: 4 data credits.
        lim_ph = 8'd4; lim_pd = 12'd8;
        do_update(blk);
        send_tlp("mwr16", 32'h4000_0010, 16, 32'hD200_0000);
        check("mwr16_cc_ph", 64'(cc_ph), 64'd1);
        check("mwr16_cc_pd", 64'(cc_pd), 64'd4);
        check("mwr16_blocked", 64'(blocked_o), 64'd0);

        // Reset in the middle of a TLP drops it with no tlast.
        push_hdr(32'h4000_0010, 1'b0, ok);
        wait_hdr(lat, beat);
        check("midrst_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 2; i++) begin
            s_tdata = 32'hBEEF_0000 + 32'(i);
            s_tlast = 1'b0;
            s_tvalid = 1'b1;
            step(1);
        end
        s_tdata = 32'hBEEF_0002;
        @(negedge clk);
        check("midrst_streaming", 64'(m_axis_tvalid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_mvalid", 64'({m_axis_tvalid, m_axis_tlast}), 64'd0);
        check("midrst_mdata", 64'(m_axis_tdata), 64'd0);
        check("midrst_sready", 64'(s_axis_tready), 64'd0);
        check("midrst_cc_pd", 64'(cc_pd), 64'd0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lim_ph = 8'd0; lim_nph = 8'd0; lim_pd = 12'd0;
        step(1);

        // MWr len 40 needs 10 data credits; 8 is not enough, 20 is.
        lim_ph = 8'd4; lim_pd = 12'd8;
        do_update(blk);
        push_hdr(32'h4000_0028, 1'b0, ok);
        check("mwr40_accept", 64'(ok), 64'd1);
        check_blocked("mwr40");
        lim_pd = 12'd20;
        do_update(blk);
        check("mwr40_old_limit", 64'(blk), 64'd1);
        wait_hdr(lat, beat);
        check("mwr40_latency", 64'(lat), 64'd1);
        send_body(40, 32'h4040_0000, lat);
        check("mwr40_body", 64'(lat), 64'd0);
        check("mwr40_cc", 64'({cc_ph, cc_pd}), 64'({8'd1, 12'd10}));

        // CplD with length 0 means 1024 DW = 256 data credits.
        do_reset();
        lim_cplh = 8'd1; lim_cpld = 12'd256;
        do_update(blk);
        send_tlp("cpld1024", 32'h4A00_0000, 1024, 32'hC000_0000);
        check("cpld1024_cc", 64'({cc_cplh, cc_cpld}), 64'({8'd1, 12'd256}));
        push_hdr(32'h4A00_0000, 1'b0, ok);
        check("cpld_second_accept", 64'(ok), 64'd1);
        check_blocked("cpld_second");

        // Walk cc_pd up to 4090, then cross the 12-bit wrap.
        do_reset();
        lim_ph = 8'd100;
        cum = 0;
        for (int k = 0; k < 15; k++) begin
            lim_pd = 12'(cum + 256);
            do_update(blk);
            send_tlp("wrap_fill", 32'h4000_0000, 1024, 32'(k) << 16);
            cum += 256;
        end
        lim_pd = 12'(cum + 250);
        do_update(blk);
        send_tlp("wrap_fill_last", 32'h4000_03E8, 1000, 32'h00FF_0000);
        check("wrap_cc_pd_pre", 64'(cc_pd), 64'd4090);
        lim_pd = 12'd6;
        do_update(blk);
        send_tlp("wrap_cross", 32'h4000_0020, 32, 32'hAA00_0000);
        check("wrap_cc_pd_post", 64'(cc_pd), 64'd2);
        check("wrap_cc_ph", 64'(cc_ph), 64'd17);

        // Header window edge: 128 ahead passes, 129 ahead blocks.
        lim_ph = 8'd146;
        do_update(blk);
        send_tlp("win128", 32'h3000_0000, 0, 32'h0);
        check("win128_cc_ph", 64'(cc_ph), 64'd18);
        lim_ph = 8'd148;
        do_update(blk);
        push_hdr(32'h3000_0000, 1'b1, ok);
        check("win129_accept", 64'(ok), 64'd1);
        check_blocked("win129");
        check("win129_cc_ph", 64'(cc_ph), 64'd18);
`else
        // cpld advertised as 0 on the first update becomes infinite.
        lim_cplh = 8'd10; lim_cpld = 12'd0;
        do_update(blk);
        for (int k = 0; k < 10; k++)
            send_tlp("inf_cpld", 32'h4A00_0040, 64, 32'(k) << 16);
        check("inf_cc_cpld", 64'(cc_cpld), 64'd0);
        check("inf_cc_cplh", 64'(cc_cplh), 64'd10);
        push_hdr(32'h4A00_0040, 1'b0, ok);
        check("inf_hdr_exhaust_accept", 64'(ok), 64'd1);
        check_blocked("inf_hdr_exhaust");
        // After reset a nonzero first update makes the field finite, and stays so.
        do_reset();
        lim_cplh = 8'd10; lim_cpld = 12'd5;
        do_update(blk);
        push_hdr(32'h4A00_0040, 1'b0, ok);
        check("fin_accept", 64'(ok), 64'd1);
        check_blocked("fin_cpld");
        lim_cpld = 12'd0;
        do_update(blk);
        check_blocked("fin_sticky");
        check("fin_cc_cpld", 64'(cc_cpld), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
